// File: rtl/wide_dec_pkg.sv
// rtl/wide_dec_pkg.sv - shared types, constants and sizing helper for the decimal serializer
package wide_dec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    // Decimal digits of 2**w-1, using log10(2) ~= 0.30103.
    function automatic int ndigits(int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 to a BCD digit of 5 or more
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/wide_bin2dec_serializer.sv
// rtl/wide_bin2dec_serializer.sv - wide unsigned binary to ASCII decimal character stream, MSD first
module wide_bin2dec_serializer
    import wide_dec_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter bit PAD   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last
);

    localparam int NDIG = ndigits(WIDTH);
    localparam int BW   = NDIG * 4;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int IW   = $clog2(NDIG);

    state_e          state;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   bit_cnt;
    logic [IW-1:0]   dig_idx;
    logic [IW-1:0]   sel_idx;
    logic            lead;
    logic [3:0]      dig;
    logic            is_lead;

    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (bcd[g*4 +: 4]),
            .q (bcd_adj[g*4 +: 4])
        );
    end

    assign in_ready = (state == IDLE);

    // While a character is presented, dig_idx names it and the next candidate is one below;
    // while nothing is presented, dig_idx itself is the next candidate.
    always_comb begin
        sel_idx = out_valid ? dig_idx - 1'b1 : dig_idx;
        dig     = bcd[sel_idx*4 +: 4];
        is_lead = lead && (dig == 4'd0) && (sel_idx != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            dig_idx   <= '0;
            lead      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_char  <= CH_SPACE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin     <= in_data;
                        bcd     <= '0;
                        bit_cnt <= CW'(WIDTH);
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd     <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
                    bin     <= {bin[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == CW'(1)) begin
                        dig_idx <= IW'(NDIG - 1);
                        lead    <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (!(out_valid && !out_ready)) begin
                        if (out_valid && dig_idx == '0) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            lead <= is_lead;
                            if (is_lead && !PAD) begin
                                out_valid <= 1'b0;
                                dig_idx   <= sel_idx - 1'b1;
                            end else begin
                                out_valid <= 1'b1;
                                dig_idx   <= sel_idx;
                                out_last  <= (sel_idx == '0);
                                out_char  <= is_lead ? CH_SPACE : CH_ZERO + {4'd0, dig};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_bin2dec_serializer.sv
// tb/tb_wide_bin2dec_serializer.sv - directed self-checking bench for wide_bin2dec_serializer
module tb_wide_bin2dec_serializer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          out_ready = 1'b1;
    logic [7:0]    in8 = '0;
    logic [1023:0] in1k = '0;
    logic          iv_p = 1'b0, iv_z = 1'b0, iv_k = 1'b0;
    logic          ir_p, ir_z, ir_k;
    logic          ov_p, ov_z, ov_k;
    logic [7:0]    oc_p, oc_z, oc_k;
    logic          ol_p, ol_z, ol_k;

    int            sel = 0;
    logic          s_ir, s_ov, s_ol;
    logic [7:0]    s_oc;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    wide_bin2dec_serializer #(.WIDTH(8), .PAD(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_p), .in_ready(ir_p), .in_data(in8),
        .out_valid(ov_p), .out_ready(out_ready), .out_char(oc_p), .out_last(ol_p));

    wide_bin2dec_serializer #(.WIDTH(8), .PAD(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_z), .in_ready(ir_z), .in_data(in8),
        .out_valid(ov_z), .out_ready(out_ready), .out_char(oc_z), .out_last(ol_z));

    wide_bin2dec_serializer #(.WIDTH(1024), .PAD(1'b1)) dut_k (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_k), .in_ready(ir_k), .in_data(in1k),
        .out_valid(ov_k), .out_ready(out_ready), .out_char(oc_k), .out_last(ol_k));

    always_comb begin
        case (sel)
            0:       begin s_ir = ir_p; s_ov = ov_p; s_oc = oc_p; s_ol = ol_p; end
            1:       begin s_ir = ir_z; s_ov = ov_z; s_oc = oc_z; s_ol = ol_z; end
            default: begin s_ir = ir_k; s_ov = ov_k; s_oc = oc_k; s_ol = ol_k; end
        endcase
    end

    // Reference decimal text by repeated division by ten.
    function automatic string dec_str(input logic [1023:0] v, input int nd, input bit pad);
        logic [1023:0] x, r;
        byte           dg [0:308];
        string         s;
        bit            lz;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r     = x % 1024'd10;
            dg[i] = byte'(r[3:0]);
            x     = x / 1024'd10;
        end
        s  = "";
        lz = 1'b1;
        for (int i = nd - 1; i >= 0; i--) begin
            if (lz && dg[i] == 0 && i != 0) begin
                if (pad) s = {s, " "};
            end else begin
                lz = 1'b0;
                s  = $sformatf("%s%0d", s, dg[i]);
            end
        end
        return s;
    endfunction

    function automatic int first_diff(input string a, input string b);
        int n = (a.len() < b.len()) ? a.len() : b.len();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        return n;
    endfunction

    // Feeds one operand to the selected instance and gathers the accepted characters.
    task automatic collect(input int which, input logic [1023:0] val, input bit rnd, input int maxc,
                           output string s, output int lat, output int stall_bad,
                           output int ir_bad, output bit tmo);
        bit         prev_stall = 1'b0;
        bit         done = 1'b0;
        logic [7:0] pc = '0;
        logic       pl = 1'b0;
        int         cyc = 0;
        sel = which; s = ""; lat = -1; stall_bad = 0; ir_bad = 0;
        @(negedge clk);
        in8 = val[7:0];
        in1k = val;
        case (which)
            0: iv_p = 1'b1;
            1: iv_z = 1'b1;
            default: iv_k = 1'b1;
        endcase
        @(posedge clk);
        #1;
        iv_p = 1'b0; iv_z = 1'b0; iv_k = 1'b0;
        in8 = 8'hA5; in1k = '1;
        while (!done && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_ir) ir_bad++;
            if (prev_stall && (!s_ov || s_oc !== pc || s_ol !== pl)) stall_bad++;
            if (s_ov && lat < 0) lat = cyc - 1;
            if (s_ov && out_ready) begin
                s = $sformatf("%s%c", s, s_oc);
                if (s_ol) done = 1'b1;
            end
            prev_stall = s_ov && !out_ready;
            pc = s_oc;
            pl = s_ol;
        end
        tmo = !done;
        if (done) @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if ({ir_p, ir_z, ir_k} !== 3'b111) begin nerr++; $display("FAIL reset_in_ready_low got %b exp 111", {ir_p, ir_z, ir_k}); end
        nvec++; if ({ov_p, ov_z, ov_k} !== 3'b000) begin nerr++; $display("FAIL reset_out_valid got %b exp 000", {ov_p, ov_z, ov_k}); end
        nvec++; if ({ol_p, ol_z, ol_k} !== 3'b000) begin nerr++; $display("FAIL reset_out_last got %b exp 000", {ol_p, ol_z, ol_k}); end
        nvec++; if (oc_p !== 8'h20 || oc_z !== 8'h20 || oc_k !== 8'h20) begin nerr++; $display("FAIL reset_out_char got %h/%h/%h exp 20", oc_p, oc_z, oc_k); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++; if ({ir_p, ir_z, ir_k, ov_p, ov_z, ov_k} !== 6'b111000) begin nerr++; $display("FAIL reset_after_release got %b exp 111000", {ir_p, ir_z, ir_k, ov_p, ov_z, ov_k}); end
    endtask

    task automatic test_basic;
        string s; int lat, sb, ib; bit tmo;
        collect(0, 1024'd255, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo) begin nerr++; $display("FAIL basic_timeout got no out_last exp out_last"); end
        nvec++; if (s != "255") begin nerr++; $display("FAIL basic_255 got '%s' exp '255'", s); end
        nvec++; if (lat != 9) begin nerr++; $display("FAIL basic_latency got %0d exp 9", lat); end
        nvec++; if (ib != 0) begin nerr++; $display("FAIL basic_in_ready_busy got %0d exp 0", ib); end
        nvec++; if (s_ov !== 1'b0 || s_ir !== 1'b1) begin nerr++; $display("FAIL basic_done_idle got ov=%b ir=%b exp ov=0 ir=1", s_ov, s_ir); end
    endtask

    task automatic test_small;
        string s; int lat, sb, ib; bit tmo;
        collect(0, 1024'd5, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "  5") begin nerr++; $display("FAIL small_pad1 got '%s' tmo=%0d exp '  5'", s, tmo); end
        collect(1, 1024'd5, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "5") begin nerr++; $display("FAIL small_pad0 got '%s' tmo=%0d exp '5'", s, tmo); end
        collect(1, 1024'd47, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "47") begin nerr++; $display("FAIL small_pad0_47 got '%s' tmo=%0d exp '47'", s, tmo); end
    endtask

    task automatic test_zero;
        string s; int lat, sb, ib; bit tmo;
        collect(1, 1024'd0, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "0") begin nerr++; $display("FAIL zero_pad0 got '%s' tmo=%0d exp '0'", s, tmo); end
        collect(0, 1024'd0, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "  0") begin nerr++; $display("FAIL zero_pad1 got '%s' tmo=%0d exp '  0'", s, tmo); end
    endtask

    task automatic test_wide;
        string s, e; int lat, sb, ib; bit tmo;
        logic [1023:0] v;
        v = '1;
        e = dec_str(v, 309, 1'b1);
        collect(2, v, 1'b0, 3000, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s.len() != 309) begin nerr++; $display("FAIL wide_ones_len got %0d tmo=%0d exp 309", s.len(), tmo); end
        nvec++; if (s.substr(0, 23) != "179769313486231590772930") begin nerr++; $display("FAIL wide_ones_head got '%s' exp '179769313486231590772930'", s.substr(0, 23)); end
        nvec++; if (s.substr(303, 308) != "137215") begin nerr++; $display("FAIL wide_ones_tail got '%s' exp '137215'", s.substr(303, 308)); end
        nvec++; if (s != e) begin nerr++; $display("FAIL wide_ones_text got differs at index %0d exp model text", first_diff(s, e)); end
        nvec++; if (lat != 1025) begin nerr++; $display("FAIL wide_latency got %0d exp 1025", lat); end
        v = 1024'h1 << 1023;
        v = v >> 1023;
        e = "";
        repeat (308) e = {e, " "};
        e = {e, "1"};
        collect(2, v, 1'b0, 3000, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != e) begin nerr++; $display("FAIL wide_one got len %0d diff at %0d exp 308 spaces then 1", s.len(), first_diff(s, e)); end
    endtask

    task automatic test_backpressure;
        string s; int lat, sb, ib; bit tmo;
        for (int k = 0; k < 3; k++) begin
            collect(0, 1024'd255, 1'b1, 300, s, lat, sb, ib, tmo);
            nvec++; if (tmo || s != "255") begin nerr++; $display("FAIL bp_stream_%0d got '%s' tmo=%0d exp '255'", k, s, tmo); end
            nvec++; if (sb != 0) begin nerr++; $display("FAIL bp_stable_%0d got %0d changes exp 0", k, sb); end
            nvec++; if (ib != 0) begin nerr++; $display("FAIL bp_in_ready_%0d got %0d exp 0", k, ib); end
        end
    endtask

    task automatic test_back_to_back;
        string s; int lat, sb, ib; bit tmo;
        collect(1, 1024'd128, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "128") begin nerr++; $display("FAIL b2b_first got '%s' tmo=%0d exp '128'", s, tmo); end
        nvec++; if (s_ir !== 1'b1) begin nerr++; $display("FAIL b2b_ready got %b exp 1", s_ir); end
        collect(1, 1024'd9, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "9") begin nerr++; $display("FAIL b2b_second got '%s' tmo=%0d exp '9'", s, tmo); end
    endtask

    task automatic test_reset_mid;
        string s; int lat, sb, ib; bit tmo;
        int hs = 0;
        int cyc = 0;
        sel = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in8 = 8'd255;
        iv_p = 1'b1;
        @(posedge clk);
        #1;
        iv_p = 1'b0;
        while (hs < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_ov && out_ready) hs++;
        end
        nvec++; if (hs != 2) begin nerr++; $display("FAIL rstmid_two_chars got %0d exp 2", hs); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++; if (s_ov !== 1'b0 || s_ol !== 1'b0 || s_ir !== 1'b1) begin nerr++; $display("FAIL rstmid_abort got ov=%b last=%b ir=%b exp ov=0 last=0 ir=1", s_ov, s_ol, s_ir); end
        @(negedge clk);
        rst_n = 1'b1;
        collect(0, 1024'd100, 1'b0, 100, s, lat, sb, ib, tmo);
        nvec++; if (tmo || s != "100") begin nerr++; $display("FAIL rstmid_fresh got '%s' tmo=%0d exp '100'", s, tmo); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_zero();
        test_wide();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
